// File: rtl/pop_cnt_pkg.sv
// ============================================================================
// Module   : pop_cnt_pkg
// Purpose  : Shared FSM state type and default sizing for pop_counter_bank.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pop_cnt_pkg;

  localparam int NCH_DEF  = 5;
  localparam int CW_DEF   = 5;
  localparam int IDXW_DEF = 3;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_READ = 2'd1,
    S_DUMP = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pop_cnt_lane.sv
// ============================================================================
// Module   : pop_cnt_lane
// Purpose  : One channel: pop counter plus sticky overflow flag.
//            Define POP_CNT_SATURATE_EN to saturate instead of wrapping.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pop_cnt_lane #(
  parameter int CW = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          pop_i,
  output logic [CW-1:0] cnt_o,
  output logic          ovf_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          w_full;

  assign w_full = &cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (pop_i) begin
      ovf_d = ovf_q | w_full;
`ifdef POP_CNT_SATURATE_EN
      cnt_d = w_full ? cnt_q : cnt_q + CW'(1);
`else
      cnt_d = cnt_q + CW'(1);
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

`default_nettype wire

// File: rtl/pop_counter_bank.sv
// ============================================================================
// Module   : pop_counter_bank
// Purpose  : Bank of per-FIFO pop counters with single-read and full-dump
//            readout. Define POP_CNT_SATURATE_EN for saturating counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pop_counter_bank
  import pop_cnt_pkg::*;
#(
  parameter int NCH  = NCH_DEF,
  parameter int CW   = CW_DEF,
  parameter int IDXW = IDXW_DEF
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic [NCH-1:0]  pop,
  input  logic            req,
  input  logic            IDLE,
  input  logic [IDXW-1:0] idx,
  output logic [CW-1:0]   data,
  output logic            valid,
  output logic [IDXW-1:0] data_idx,
  output logic            busy,
  output logic [NCH-1:0]  ovf,
  output logic            err
);

  localparam logic [IDXW:0]   C_NCH_W    = (IDXW+1)'(NCH);
  localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(NCH-1);

  logic [NCH-1:0][CW-1:0] cnt_w;

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    pop_cnt_lane #(.CW(CW)) u_lane (
      .clk_i (CLK),
      .rst_i (reset),
      .pop_i (pop[g]),
      .cnt_o (cnt_w[g]),
      .ovf_o (ovf[g])
    );
  end

  state_t                 state_q, state_d;
  logic                   idle_q;
  logic [CW-1:0]          rd_data_q, rd_data_d;
  logic [IDXW-1:0]        rd_idx_q, rd_idx_d;
  logic [NCH-1:0][CW-1:0] snap_q, snap_d;
  logic [IDXW-1:0]        dump_idx_q, dump_idx_d;
  logic                   err_q, err_d;

  logic                   w_idle_rise;
  logic                   w_idx_ok;
  logic [CW-1:0]          w_live_sel;
  logic [CW-1:0]          w_snap_sel;

  assign w_idle_rise = IDLE & ~idle_q;
  assign w_idx_ok    = {1'b0, idx} < C_NCH_W;

  // Explicit muxes keep out-of-range index values from ever selecting a lane.
  always_comb begin
    w_live_sel = '0;
    w_snap_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (idx == IDXW'(i))        w_live_sel = cnt_w[i];
      if (dump_idx_q == IDXW'(i)) w_snap_sel = snap_q[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_data_d  = rd_data_q;
    rd_idx_d   = rd_idx_q;
    snap_d     = snap_q;
    dump_idx_d = dump_idx_q;
    err_d      = 1'b0;
    valid      = 1'b0;
    data       = '0;
    data_idx   = '0;
    busy       = 1'b0;

    case (state_q)
      S_WAIT: begin
        // An IDLE edge wins over a same-cycle req, which is silently dropped.
        if (w_idle_rise) begin
          snap_d     = cnt_w;
          dump_idx_d = '0;
          state_d    = S_DUMP;
        end else if (req) begin
          if (w_idx_ok) begin
            rd_data_d = w_live_sel;
            rd_idx_d  = idx;
            state_d   = S_READ;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_READ: begin
        busy     = 1'b1;
        valid    = 1'b1;
        data     = rd_data_q;
        data_idx = rd_idx_q;
        err_d    = req;
        state_d  = S_WAIT;
      end
      S_DUMP: begin
        busy       = 1'b1;
        valid      = 1'b1;
        data       = w_snap_sel;
        data_idx   = dump_idx_q;
        err_d      = req;
        dump_idx_d = dump_idx_q + IDXW'(1);
        if (dump_idx_q == C_LAST_IDX) state_d = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= S_WAIT;
      idle_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_idx_q   <= '0;
      snap_q     <= '0;
      dump_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_q     <= IDLE;
      rd_data_q  <= rd_data_d;
      rd_idx_q   <= rd_idx_d;
      snap_q     <= snap_d;
      dump_idx_q <= dump_idx_d;
      err_q      <= err_d;
    end
  end

  assign err = err_q;

endmodule

`default_nettype wire

// File: doc/pop_counter_bank.md
POP_COUNTER_BANK -- requirements
Module: pop_counter_bank

Interface
REQ-001 SHALL have parameter NCH, default 5, meaning the number of FIFO channels counted (range 1..8).
REQ-002 SHALL have parameter CW, default 5, meaning the counter width in bits.
REQ-003 SHALL have parameter IDXW, default 3, meaning the index width, with 2**IDXW >= NCH.
REQ-004 SHALL have port CLK  input  1  as the single clock; all logic is on the rising edge.
REQ-005 SHALL have port reset  input  1  as the synchronous, active-high reset.
REQ-006 SHALL have port pop  input  NCH  carrying one pop strobe per FIFO; bit i counts channel i.
REQ-007 SHALL have port req  input  1  as the single-counter read request.
REQ-008 SHALL have port IDLE  input  1  meaning the system is idle; its rising edge starts a full dump.
REQ-009 SHALL have port idx  input  IDXW  selecting the channel for a req read.
REQ-010 SHALL have port data  output  CW  carrying the counter value being read.
REQ-011 SHALL have port valid  output  1  flagging that data is valid this cycle.
REQ-012 SHALL have port data_idx  output  IDXW  carrying the channel number of the current data.
REQ-013 SHALL have port busy  output  1  indicating a read or dump is in progress.
REQ-014 SHALL have port ovf  output  NCH  holding sticky per-channel overflow flags.
REQ-015 SHALL have port err  output  1  pulsing for one cycle when a read is rejected.

Function
REQ-016 SHALL increment counter i by 1 on each CLK edge where pop[i]=1; channels are independent, and any combination may be set at once.
REQ-017 SHALL, when counter i is all-ones and pop[i]=1, set ovf[i]; ovf[i] SHALL stay set until reset.
REQ-018 SHALL use FSM states S_WAIT, S_READ, S_DUMP, with S_WAIT as the reset state.
REQ-019 SHALL, in S_WAIT with req=1 and idx<NCH, capture counter[idx] and go to S_READ.
REQ-020 SHALL, in S_READ, drive valid=1, data=captured value and data_idx=idx for exactly one cycle, then return to S_WAIT; read latency is 1 cycle from req.
REQ-021 SHALL, in S_WAIT with req=1 and idx>=NCH, stay in S_WAIT, pulse err=1 for one cycle and keep valid=0.
REQ-022 SHALL, on an IDLE rising edge (IDLE=1 now, 0 last cycle) in S_WAIT, snapshot all NCH counters in that cycle and enter S_DUMP.
REQ-023 SHALL, in S_DUMP, emit snapshot entries 0..NCH-1 on consecutive cycles with valid=1 and data_idx=entry, then return to S_WAIT.
REQ-024 SHALL give the IDLE edge priority over req when both occur in the same S_WAIT cycle; that req is dropped and err is not raised.
REQ-025 SHALL hold busy=1 in S_READ and S_DUMP; a req or IDLE edge arriving while busy=1 SHALL be ignored and SHALL raise err on req only.
REQ-026 SHALL make captured values the pre-increment count when a pop coincides with the capture edge; that pop is still counted.
REQ-027 SHALL keep counting pops during S_READ and S_DUMP; emitted values are the snapshot, not the live counts.
REQ-028 SHALL drive data=0 and data_idx=0 whenever valid=0 (no X).

Reset
REQ-029 SHALL, when reset=1 at a CLK edge, clear all counters, ovf, snapshots and the stored IDLE history, set data=0, data_idx=0, valid=0, busy=0, err=0, and put the FSM in S_WAIT.
REQ-030 SHALL abort any read or dump in progress when reset is asserted mid-operation; no further valid pulses follow.
REQ-031 SHALL give reset priority over pop, req and IDLE in the same cycle.

Configuration
REQ-032 SHALL, with macro POP_CNT_SATURATE_EN defined, hold counters at all-ones once reached (saturating) while ovf still sets.
REQ-033 SHALL, without POP_CNT_SATURATE_EN, wrap counters from all-ones to 0.

Structure
REQ-034 SHALL place in package pop_cnt_pkg the FSM state typedef (S_WAIT, S_READ, S_DUMP) and the default constants NCH_DEF=5, CW_DEF=5, IDXW_DEF=3.
REQ-035 SHALL implement each channel as an instance of sub-module pop_cnt_lane (counter plus sticky ovf, width CW), generated NCH times.

Verification
REQ-036 SHALL cover: reset, 3 pops on channel 2, req with idx=2 -> next cycle valid=1, data=3, data_idx=2.
REQ-037 SHALL cover: 32 pops on channel 0 with CW=5 -> wrap build: count=0 and ovf[0]=1; saturate build: count=31 and ovf[0]=1.
REQ-038 SHALL cover: counts {1,2,3,4,5}, IDLE rising -> 5 consecutive valid cycles, data=1..5 and data_idx=0..4, busy=1 throughout.
REQ-039 SHALL cover: req with idx=6 while NCH=5 -> err pulse of one cycle, valid stays 0.
REQ-040 SHALL cover: pop[1] on the capture edge with count 4 -> data=4, and a later read returns 5.
REQ-041 SHALL cover: reset asserted on the 3rd dump cycle -> valid=0 from the next cycle on, all counters 0, FSM back in S_WAIT.
